rf_bypass_sb: RTL
=================

Name: rf_bypass_sb

Overview:
- Parametrised successor of the 8x16 two-read/one-write register file with write-to-read bypass.
- Generalised in data width, register count and read-port count.
- Adds a per-register pending scoreboard (issue sets, writeback clears) so decode can detect RAW hazards on in-flight producers.
- Adds a sticky error flag for illegal register selects.
- Sits at decode/writeback of the pipelined core.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers, 2..64; need not be a power of two.
- NUM_RD, 2, number of read ports, 1..4.
- AW (localparam), clog2(NREGS), select width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_sel  input  NUM_RD*AW  read selects; port i occupies bits [i*AW +: AW].
- rd_data  output  NUM_RD*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH].
- rd_busy  output  NUM_RD  port i source register has an in-flight producer.
- wr_en  input  1  write strobe.
- wr_sel  input  AW  write register select.
- wr_data  input  WIDTH  write data.
- iss_en  input  1  instruction issued with a destination register; mark it pending.
- iss_sel  input  AW  destination register of the issued instruction.
- pend  output  NREGS  scoreboard vector, bit r set = register r pending.
- err  output  1  sticky illegal-select flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0, pend = 0, err = 0.
  - rd_data then reflects the zeroed array, bypass still applies; rd_busy = 0.
- Write:
  - on a rising edge with wr_en=1 and wr_sel<NREGS, reg[wr_sel] <= wr_data.
  - wr_en=1 with wr_sel>=NREGS: array unchanged.
- Read (combinational, zero latency):
  - rd_data[i] = wr_data if wr_en=1 and rd_sel[i]==wr_sel and wr_sel<NREGS; otherwise reg[rd_sel[i]].
  - rd_sel[i]>=NREGS returns 0.
  - Multiple ports selecting the same register each get identical data.
- Scoreboard, updated on rising edge:
  - wr_en=1 with legal wr_sel clears pend[wr_sel].
  - iss_en=1 with legal iss_sel sets pend[iss_sel].
  - Same register set and cleared in the same cycle: set wins, since the new producer is younger.
  - iss_en=1 for an already-pending register: stays 1, no error.
  - wr_en=1 for a non-pending register: the write occurs; pend stays 0.
- Busy (combinational):
  - rd_busy[i] = pend[rd_sel[i]] & ~(wr_en & rd_sel[i]==wr_sel).
  - The result arriving this cycle is bypassed, so the port is not busy.
  - iss_en in the same cycle does not affect rd_busy until the next cycle.
- Error:
  - err <= 1 on the rising edge after any cycle with wr_en=1 and wr_sel>=NREGS, or iss_en=1 and iss_sel>=NREGS.
  - Illegal read selects do not set err.
  - err stays 1 until reset; one-cycle latency.
  - Illegal select when NREGS is a power of two is impossible; err stays 0.
- Reset mid-operation: pending bits and err clear immediately; in-flight writes are lost.
- No X-propagation from unwritten registers; all are defined after reset.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired zero; writes to it are discarded.
  - No bypass for register 0: reads always return 0, even when wr_en=1, wr_sel=0.
  - pend[0] is never set and rd_busy for register 0 is always 0.
  - Writes or issues to register 0 are legal (no err).
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read: release rst, rd_sel={3,0} -> rd_data=0 on both ports, pend=0, err=0, rd_busy=0.
- Bypass:
  - stimulus: wr_en=1, wr_sel=5, wr_data=16'hBEEF, rd_sel port0=5 in the same cycle.
  - response: port0 shows 16'hBEEF before the edge; after the edge, with wr_en=0, reg 5 reads 16'hBEEF.
- Scoreboard:
  - stimulus: iss_en=1, iss_sel=2; next cycle rd_sel port1=2.
  - response: pend[2]=1, rd_busy[1]=1. Then wr_en=1, wr_sel=2, wr_data=16'h0042 -> same cycle rd_busy[1]=0, rd_data=16'h0042; next cycle pend[2]=0.
- Set/clear collision:
  - stimulus: pend[4]=1; in one cycle iss_en=1, iss_sel=4 and wr_en=1, wr_sel=4, wr_data=7.
  - response: reg4=7, pend[4] remains 1.
- Illegal select:
  - stimulus: NREGS=6, wr_en=1, wr_sel=6, wr_data=16'hFFFF.
  - response: array unchanged, err=1 the next cycle and held; rd_sel=7 reads 0. Assert rst=0 -> err=0 immediately.
- Zero register, RF_ZERO_REG_EN defined:
  - stimulus: wr_en=1, wr_sel=0, wr_data=16'h1234, iss_en=1, iss_sel=0.
  - response: rd_data=0 same cycle and after; pend[0]=0; err=0.

Source files
------------

// File: rtl/rf_bypass_sb_if.sv
// Register-file bus: read selects/data/busy, write and issue strobes,
// plus the scoreboard vector and sticky error flag seen by decode.
interface rf_bypass_sb_if #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]    rd_sel;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    wr_en;
  logic [AW-1:0]           wr_sel;
  logic [WIDTH-1:0]        wr_data;
  logic                    iss_en;
  logic [AW-1:0]           iss_sel;
  logic [NREGS-1:0]        pend;
  logic                    err;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
    input  rd_data, rd_busy, pend, err
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
    output rd_data, rd_busy, pend, err
  );
endinterface

// File: rtl/rf_bypass_sb.sv
// Parametrised register file with write-to-read bypass, pending scoreboard and
// sticky illegal-select flag. Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module rf_bypass_sb #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int NUM_RD = 2
) (
  input  logic          clk,
  input  logic          rst,
  rf_bypass_sb_if.slave bus
);
  localparam int AW   = $clog2(NREGS);
  localparam bit POW2 = (NREGS == (1 << AW));
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic             err_q;
  logic             wr_legal;
  logic             iss_legal;
  logic             wr_commit;
  logic             iss_commit;

  // With a power-of-two register count every select encodes a real register.
  generate
    if (POW2) begin : g_legal_pow2
      assign wr_legal  = 1'b1;
      assign iss_legal = 1'b1;
    end else begin : g_legal_cmp
      assign wr_legal  = (bus.wr_sel  < AW'(NREGS));
      assign iss_legal = (bus.iss_sel < AW'(NREGS));
    end
  endgenerate

  assign wr_commit  = bus.wr_en  & wr_legal  & ~(ZERO_REG && (bus.wr_sel  == '0));
  assign iss_commit = bus.iss_en & iss_legal & ~(ZERO_REG && (bus.iss_sel == '0));

  // Issue is applied after writeback so a younger producer keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr_commit) begin
      pend_d[bus.wr_sel] = 1'b0;
    end
    if (iss_commit) begin
      pend_d[bus.iss_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wr_commit) begin
        regs[bus.wr_sel] <= bus.wr_data;
      end
      pend_q <= pend_d;
      if ((bus.wr_en & ~wr_legal) | (bus.iss_en & ~iss_legal)) begin
        err_q <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] sel;
      logic          sel_in;
      logic          sel_ok;
      logic          fwd;

      assign sel = bus.rd_sel[i*AW +: AW];

      if (POW2) begin : g_in_pow2
        assign sel_in = 1'b1;
      end else begin : g_in_cmp
        assign sel_in = (sel < AW'(NREGS));
      end

      assign sel_ok = sel_in & ~(ZERO_REG && (sel == '0));
      assign fwd    = wr_commit & (bus.wr_sel == sel);

      assign bus.rd_data[i*WIDTH +: WIDTH] = !sel_ok ? '0 :
                                             fwd     ? bus.wr_data :
                                                       regs[sel];
      // A result landing this cycle is forwarded, so it no longer stalls the reader.
      assign bus.rd_busy[i] = sel_in & pend_q[sel] & ~(bus.wr_en & (sel == bus.wr_sel));
    end
  endgenerate

  assign bus.pend = pend_q;
  assign bus.err  = err_q;
endmodule
